// File: rtl/deblock_pkg.sv
// rtl/deblock_pkg.sv - shared types and helpers for the streaming deblocking filter
package deblock_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ALL    = 2'd1,
        MODE_EDGE   = 2'd2,
        MODE_RSVD   = 2'd3
    } deblock_mode_e;

    // Sideband markers that travel with a pixel through the hold and output stages
    typedef struct packed {
        logic sof;
        logic eol;
    } pix_sb_t;

    // Counter width that stays legal for a geometry of a single pixel or row
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deblock_pair_filter.sv
// rtl/deblock_pair_filter.sv - threshold test and floor average of two raw pixels
module deblock_pair_filter #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] threshold,
    output logic             filt_en,
    output logic [PIX_W-1:0] avg
);

    logic [PIX_W:0] a_ext;
    logic [PIX_W:0] b_ext;
    logic [PIX_W:0] diff;

    // One extra bit keeps the sum exact; the shifted result always fits back in PIX_W
    always_comb begin
        a_ext   = {1'b0, a};
        b_ext   = {1'b0, b};
        diff    = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
        filt_en = (diff < {1'b0, threshold});
        avg     = PIX_W'((a_ext + b_ext) >> 1);
    end

endmodule

// File: rtl/deblock_stream_filter.sv
// rtl/deblock_stream_filter.sv - streaming horizontal deblocking filter with hold and output stages
module deblock_stream_filter
    import deblock_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int N      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cfg_mode,
    input  logic [PIX_W-1:0] cfg_threshold,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             frame_done,
    output logic             err_sync
);

    localparam int XW    = cnt_w(WIDTH);
    localparam int YW    = cnt_w(HEIGHT);
    localparam int LOG_N = $clog2(N);

    localparam logic [XW-1:0]    X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [LOG_N-1:0] BLK_LAST = LOG_N'(N - 1);

    // Position of the next expected input pixel
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    // Configuration frozen for the duration of a frame
    deblock_mode_e    mode_q;
    logic [PIX_W-1:0] thr_q;

    // Hold stage: current pixel plus its raw left neighbour
    logic             h_valid;
    logic [PIX_W-1:0] h_data;
    logic [PIX_W-1:0] h_left;
    logic [XW-1:0]    h_x;
    logic [YW-1:0]    h_y;
    pix_sb_t          h_sb;

    // Output stage extras
    pix_sb_t          m_sb;
    logic             m_last;

    logic             out_free;
    logic             s_fire;
    logic [XW-1:0]    in_x;
    logic [YW-1:0]    in_y;
    logic             in_x_last;
    logic             in_eol;
    logic             sync_err;
    logic             h_end;
    logic             h_adv;

    logic             r_en;
    logic [PIX_W-1:0] r_avg;
    logic             l_en;
    logic [PIX_W-1:0] l_avg;
    logic             use_right;
    logic             use_left;
    logic [PIX_W-1:0] out_data;

    // Right neighbour: held pixel against the pixel being accepted now
    deblock_pair_filter #(.PIX_W(PIX_W)) u_right (
        .a         (h_data),
        .b         (s_data),
        .threshold (thr_q),
        .filt_en   (r_en),
        .avg       (r_avg)
    );

    // Left neighbour: raw previous pixel against the held pixel
    deblock_pair_filter #(.PIX_W(PIX_W)) u_left (
        .a         (h_left),
        .b         (h_data),
        .threshold (thr_q),
        .filt_en   (l_en),
        .avg       (l_avg)
    );

    // Handshake, position of the incoming pixel and marker consistency
    always_comb begin
        out_free  = !m_valid || m_ready;
        s_ready   = !h_valid || out_free;
        s_fire    = s_valid && s_ready;
        in_x      = s_sof ? '0 : x_cnt;
        in_y      = s_sof ? '0 : y_cnt;
        in_x_last = (in_x == X_LAST);
        in_eol    = s_eol || in_x_last;
        sync_err  = s_fire && ((s_sof && ((x_cnt != '0) || (y_cnt != '0)))
                               || (s_eol && !in_x_last)
                               || (in_x_last && !s_eol));
        // A new frame start closes whatever row the held pixel belonged to
        h_end     = h_sb.eol || (s_fire && s_sof);
        h_adv     = h_valid && out_free && (s_fire || h_end);
    end

    // Choose raw or smoothed value for the held pixel under the frame's mode
    always_comb begin
        use_right = 1'b0;
        use_left  = 1'b0;
        case (mode_q)
            MODE_ALL: begin
                use_right = !h_end && r_en;
            end
            MODE_EDGE: begin
                use_right = !h_end && (h_x[LOG_N-1:0] == BLK_LAST) && r_en;
                use_left  = (h_x[LOG_N-1:0] == '0) && (h_x != '0) && l_en;
            end
            default: begin
                use_right = 1'b0;
                use_left  = 1'b0;
            end
        endcase
        out_data = use_right ? r_avg : (use_left ? l_avg : h_data);
    end

    // Input position counters and per-frame configuration latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            mode_q <= MODE_BYPASS;
            thr_q  <= '0;
        end else if (s_fire) begin
            if (in_eol) begin
                x_cnt <= '0;
                y_cnt <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
            end else begin
                x_cnt <= in_x + XW'(1);
                y_cnt <= in_y;
            end
            if (s_sof) begin
                mode_q <= deblock_mode_e'(cfg_mode);
                thr_q  <= cfg_threshold;
            end
        end
    end

    // Hold stage: load each accepted pixel, keep the outgoing one as raw left neighbour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_valid <= 1'b0;
            h_data  <= '0;
            h_left  <= '0;
            h_x     <= '0;
            h_y     <= '0;
            h_sb    <= '0;
        end else if (s_fire) begin
            h_valid <= 1'b1;
            h_data  <= s_data;
            h_left  <= h_data;
            h_x     <= in_x;
            h_y     <= in_y;
            h_sb    <= '{sof: (in_x == '0) && (in_y == '0), eol: in_eol};
        end else if (h_adv) begin
            h_valid <= 1'b0;
        end
    end

    // Output stage: take the filtered held pixel whenever downstream has room
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sb    <= '0;
            m_last  <= 1'b0;
        end else if (out_free) begin
            m_valid <= h_adv;
            if (h_adv) begin
                m_data <= out_data;
                m_sb   <= '{sof: h_sb.sof, eol: h_end};
                m_last <= (h_x == X_LAST) && (h_y == Y_LAST);
            end
        end
    end

    // Registered one-cycle pulse for any marker/counter disagreement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sync <= 1'b0;
        end else begin
            err_sync <= sync_err;
        end
    end

    assign m_sof      = m_sb.sof;
    assign m_eol      = m_sb.eol;
    assign frame_done = m_valid && m_ready && m_last;

endmodule

// File: tb/tb_deblock_stream_filter.sv
// tb/tb_deblock_stream_filter.sv - scoreboard bench for the streaming deblocking filter
module tb_deblock_stream_filter;

    localparam int PW = 8;
    localparam int W  = 16;
    localparam int H  = 4;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] cfg_threshold;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          s_sof;
    logic          s_eol;
    logic          m_valid;
    logic          m_ready;
    logic [PW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          frame_done;
    logic          err_sync;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   row_buf [W];
    int   fr_mode;
    int   fr_thr;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_cnt  = 0;
    int   err_base;
    bit   err_prev = 0;
    bit   rdy_rand = 0;
    bit   val_rand = 0;

    deblock_stream_filter #(.PIX_W(PW), .WIDTH(W), .HEIGHT(H), .N(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_mode      (cfg_mode),
        .cfg_threshold (cfg_threshold),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .s_eol         (s_eol),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_sof         (m_sof),
        .m_eol         (m_eol),
        .frame_done    (frame_done),
        .err_sync      (err_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference output for pixel x of the current row of length len
    function automatic logic [7:0] exp_pix(input int x, input int len);
        int a;
        int nb;
        a = row_buf[x];
        if (fr_mode == 1 && x < len - 1) begin
            nb = row_buf[x + 1];
            if (absd(a, nb) < fr_thr) return 8'((a + nb) / 2);
        end else if (fr_mode == 2) begin
            if (x % NB == NB - 1) begin
                if (x < len - 1) begin
                    nb = row_buf[x + 1];
                    if (absd(a, nb) < fr_thr) return 8'((a + nb) / 2);
                end
            end else if (x % NB == 0 && x != 0) begin
                nb = row_buf[x - 1];
                if (absd(a, nb) < fr_thr) return 8'((a + nb) / 2);
            end
        end
        return 8'(a);
    endfunction

    task automatic fill_row(input int pat, input int y);
        for (int x = 0; x < W; x++) begin
            case (pat)
                0: row_buf[x] = (x + 16 * y) % 256;
                1: row_buf[x] = $urandom_range(90, 120);
                2: row_buf[x] = (x == 7) ? 60 : ((x == 8) ? 64 : 50);
                default: row_buf[x] = ($urandom_range(0, 1) == 1) ? 128 + $urandom_range(0, 12)
                                                                  : $urandom_range(0, 255);
            endcase
        end
        if (pat == 1 && y == 0) begin
            row_buf[0] = 100;
            row_buf[1] = 105;
            row_buf[2] = 130;
        end
    endtask

    task automatic drive_pixel(input logic [7:0] d, input logic sof, input logic eol);
        bit done;
        int guard;
        done  = 0;
        guard = 0;
        while (val_rand && $urandom_range(0, 99) < 30) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        while (!done && guard < 1000) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!done) check("accept_timeout", done, 1);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic send_row(input int y, input int len, input int stop);
        exp_t e;
        for (int x = 0; x < stop; x++) begin
            e.data = exp_pix(x, len);
            e.sof  = (x == 0 && y == 0);
            e.eol  = (x == len - 1);
            e.last = (x == W - 1 && y == H - 1);
            sb.push_back(e);
            drive_pixel(8'(row_buf[x]), e.sof, e.eol);
        end
    endtask

    task automatic send_frame(input int pat, input int short_y, input int switch_y,
                              input logic [1:0] switch_mode);
        int len;
        for (int y = 0; y < H; y++) begin
            fill_row(pat, y);
            if (y == switch_y) cfg_mode = switch_mode;
            len = (y == short_y) ? 10 : W;
            send_row(y, len, len);
        end
    endtask

    task automatic set_cfg(input int mode, input int thr);
        fr_mode       = mode;
        fr_thr        = thr;
        cfg_mode      = 2'(mode);
        cfg_threshold = 8'(thr);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    // Downstream back-pressure
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Output monitor and scoreboard comparison
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                check("output_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("m_data", m_data, mon_e.data);
                    check("m_sof", m_sof, mon_e.sof);
                    check("m_eol", m_eol, mon_e.eol);
                    check("frame_done", frame_done, mon_e.last);
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
            if (!m_valid || m_ready) check("s_ready_when_out_free", s_ready, 1);
            if (err_sync) begin
                err_cnt++;
                check("err_sync_single_cycle", err_prev, 0);
            end
            err_prev = err_sync;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        s_valid       = 1'b0;
        s_data        = '0;
        s_sof         = 1'b0;
        s_eol         = 1'b0;
        set_cfg(0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_sof", m_sof, 0);
        check("rst_m_eol", m_eol, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_sync", err_sync, 0);
        check("rst_s_ready", s_ready, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Bypass ramp
        err_base = err_cnt;
        set_cfg(0, 10);
        send_frame(0, -1, -1, 2'd0);
        drain("drain_bypass");
        check("err_bypass", err_cnt - err_base, 0);

        // All-pairs, first row 100,105,130
        set_cfg(1, 10);
        send_frame(1, -1, -1, 2'd0);
        drain("drain_all_pairs");

        // Edge-only with a block boundary step
        set_cfg(2, 10);
        send_frame(2, -1, -1, 2'd0);
        drain("drain_edge");
        check("err_clean_frames", err_cnt - err_base, 0);

        // Random back-pressure and input gaps over three frames
        rdy_rand = 1;
        val_rand = 1;
        for (int f = 0; f < 3; f++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 40));
            send_frame(3, -1, -1, 2'd0);
        end
        drain("drain_random");
        rdy_rand = 0;
        val_rand = 0;
        check("err_random", err_cnt - err_base, 0);

        // Early end of row 1 at x=9
        err_base = err_cnt;
        set_cfg(1, 30);
        send_frame(3, 1, -1, 2'd0);
        drain("drain_short_row");
        check("err_short_row", err_cnt - err_base, 1);

        // Mode change mid-frame is ignored until the next start of frame
        err_base = err_cnt;
        set_cfg(1, 20);
        send_frame(3, -1, 1, 2'd0);
        set_cfg(0, 20);
        send_frame(3, -1, -1, 2'd0);
        drain("drain_mode_switch");
        check("err_mode_switch", err_cnt - err_base, 0);

        // Reset in the middle of a row
        set_cfg(1, 20);
        fill_row(3, 0);
        send_row(0, W, 6);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_m_sof", m_sof, 0);
        check("midrst_m_eol", m_eol, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_err_sync", err_sync, 0);
        check("midrst_s_ready", s_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        err_base = err_cnt;
        set_cfg(2, 25);
        send_frame(3, -1, -1, 2'd0);
        drain("drain_after_reset");
        check("err_after_reset", err_cnt - err_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
